// File: rtl/finv_seq_if.sv
// Handshake bundle between FPU dispatch, the finv sequencer and the writeback mux.
interface finv_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        overflow;
  logic        underflow;
  logic        busy;

  modport master (
    output in_valid, s, out_ready,
    input  in_ready, out_valid, d, overflow, underflow, busy
  );

  modport slave (
    input  in_valid, s, out_ready,
    output in_ready, out_valid, d, overflow, underflow, busy
  );
endinterface

// File: rtl/finv_seq.sv
// Single-precision reciprocal by seeded Newton-Raphson on one time-shared multiplier.
// One operation in flight; result is held on the output until the consumer takes it.
module finv_seq #(
  parameter int NITER   = 2,
  parameter int MUL_LAT = 1
) (
  input  logic      clk,
  input  logic      rstn,
  finv_seq_if.slave bus
);
  localparam int NSTEP = 2 * NITER;

  typedef enum logic [2:0] {IDLE, SEED, MUL, RND, OUT} state_t;
  state_t state, state_nx;

  // Seed entry i approximates 1/(1 + (i+0.5)/256), stored as the 8 bits below the leading 1.
  function automatic int seed_val(input int i);
    int q;
    q = (2 * 262144 + (513 + 2 * i)) / (2 * (513 + 2 * i)) - 256;
    if (q > 255) q = 255;
    if (q < 0) q = 0;
    return q;
  endfunction

  logic [7:0] seed_rom [256];
  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam int V = seed_val(g);
    assign seed_rom[g] = V[7:0];
  end

  logic        sign_q;
  logic [7:0]  exp_q;
  logic [22:0] man_q;
  logic        spec_q;
  logic [31:0] om;
  logic [31:0] x;
  logic [32:0] b;
  logic [63:0] prod_q;
  logic [2:0]  step;
  logic        lat_cnt;
  logic [31:0] res_d;
  logic        res_ovf;
  logic        res_unf;

  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_man;
  assign {in_sign, in_exp, in_man} = bus.s;

  // Operands that never need the iteration: zero/denormal, inf/NaN, and results below the normal range.
  logic        special;
  logic [31:0] special_d;
  logic        special_ovf;
  logic        special_unf;
  always_comb begin
    special     = 1'b1;
    special_d   = 32'd0;
    special_ovf = 1'b0;
    special_unf = 1'b0;
    if (in_exp == 8'd0) begin
      special_d   = {in_sign, 8'hFF, 23'd0};
      special_ovf = 1'b1;
    end else if (in_exp == 8'hFF) begin
      special_d = (in_man == 23'd0) ? {in_sign, 31'd0} : 32'h7FC00000;
    end else if (in_exp == 8'd254 || (in_exp == 8'd253 && in_man != 23'd0)) begin
      special_d   = {in_sign, 31'd0};
      special_unf = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // Even steps form b = om*x, odd steps form c = b*x; b can exceed 2^32 slightly, hence 33 bits.
  logic [32:0] mul_a;
  logic [64:0] prod;
  logic [63:0] mul_res;
  logic [32:0] x_next;
  logic        step_done;
  assign mul_a     = step[0] ? b : {1'b0, om};
  assign prod      = {32'd0, mul_a} * {33'd0, x};
  assign mul_res   = (MUL_LAT == 2) ? prod_q : prod[63:0];
  assign x_next    = {x, 1'b0} - {1'b0, mul_res[63:32]};
  assign step_done = (lat_cnt == 1'(MUL_LAT - 1));

  // x holds 1/om as Q0.32 with bit 31 set, so bit 31 is the hidden one of the result.
  logic        rne;
  logic [23:0] mant_sum;
  logic [31:0] rnd_d;
  always_comb begin
    rne      = x[7] & (x[6] | (|x[5:0]) | x[8]);
    mant_sum = {1'b0, x[30:8]} + {23'd0, rne};
    if (man_q == 23'd0 || mant_sum[23]) begin
      rnd_d = {sign_q, 8'd254 - exp_q, 23'd0};
    end else begin
      rnd_d = {sign_q, 8'd253 - exp_q, mant_sum[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Special operands take one pass through RND so their output timing is fixed at one cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_nx = special ? RND : SEED;
      SEED: state_nx = MUL;
      MUL:  if (step_done && step == 3'(NSTEP - 1)) state_nx = RND;
      RND:  state_nx = OUT;
      OUT:  if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sign_q  <= 1'b0;
      exp_q   <= 8'd0;
      man_q   <= 23'd0;
      spec_q  <= 1'b0;
      om      <= 32'd0;
      x       <= 32'd0;
      b       <= 33'd0;
      prod_q  <= 64'd0;
      step    <= 3'd0;
      lat_cnt <= 1'b0;
      res_d   <= 32'd0;
      res_ovf <= 1'b0;
      res_unf <= 1'b0;
    end else begin
      prod_q <= prod[63:0];
      case (state)
        IDLE: if (bus.in_valid) begin
          {sign_q, exp_q, man_q} <= bus.s;
          spec_q  <= special;
          res_d   <= special_d;
          res_ovf <= special_ovf;
          res_unf <= special_unf;
        end
        SEED: begin
          om      <= {1'b1, man_q, 8'd0};
          x       <= {1'b1, seed_rom[man_q[22:15]], 23'd0};
          b       <= 33'd0;
          step    <= 3'd0;
          lat_cnt <= 1'b0;
        end
        MUL: begin
          if (step_done) begin
            lat_cnt <= 1'b0;
            step    <= step + 3'd1;
            if (!step[0]) b <= mul_res[63:31];
            else          x <= x_next[31:0];
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RND: if (!spec_q) res_d <= rnd_d;
        OUT: if (bus.out_ready) begin
          res_ovf <= 1'b0;
          res_unf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{x[31], x_next[32], prod[64], mul_res[30:0]};

  assign bus.in_ready  = rstn && (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.busy      = (state != IDLE);
  assign bus.d         = res_d;
  assign bus.overflow  = res_ovf;
  assign bus.underflow = res_unf;
endmodule

// File: tb/tb_finv_seq.sv
// Bench for finv_seq: exact-division reference model, per-cycle output monitor, directed and random ops.
module tb_finv_seq;
  localparam int NITER    = 2;
  localparam int MUL_LAT  = 1;
  localparam int NORM_LAT = 2 * NITER * MUL_LAT + 2;
  localparam int NRAND    = 2000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  finv_seq_if bus ();

  finv_seq #(.NITER(NITER), .MUL_LAT(MUL_LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    logic        ovf;
    logic        unf;
    bit          exact;
    bit          special;
    bit          seen;
    int          t_acc;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_results = 0;
  int          cyc = 0;
  logic [31:0] last_d = 32'd0;
  logic        last_ovf = 1'b0;
  logic        last_unf = 1'b0;

  always @(posedge clk) cyc++;

  // Reference: 1/s from exact integer division of 2^47 by the 24-bit significand, rounded to nearest even.
  function automatic exp_t refModel(input logic [31:0] s);
    exp_t r;
    logic sg;
    logic [7:0] e;
    logic [22:0] m;
    longint unsigned mm, qq, rem;
    int ex;
    sg = s[31]; e = s[30:23]; m = s[22:0];
    r.s = s; r.d = 32'd0; r.ovf = 1'b0; r.unf = 1'b0;
    r.exact = 1'b1; r.special = 1'b1; r.seen = 1'b0; r.t_acc = 0;
    if (e == 8'd0) begin
      r.d = {sg, 8'hFF, 23'd0};
      r.ovf = 1'b1;
    end else if (e == 8'hFF) begin
      r.d = (m == 23'd0) ? {sg, 31'd0} : 32'h7FC00000;
    end else begin
      r.special = 1'b0;
      if (m == 23'd0) begin
        ex = 254 - int'(e);
        qq = 64'd0;
      end else begin
        mm  = 64'd8388608 + 64'(m);
        qq  = (64'd1 << 47) / mm;
        rem = (64'd1 << 47) % mm;
        if (2 * rem > mm || (2 * rem == mm && qq[0])) qq = qq + 1;
        ex = 253 - int'(e);
        if (qq == (64'd1 << 24)) begin
          ex = ex + 1;
          qq = 64'd0;
        end
        r.exact = 1'b0;
      end
      if (ex < 1) begin
        r.d = {sg, 31'd0};
        r.unf = 1'b1;
        r.special = 1'b1;
        r.exact = 1'b1;
      end else begin
        r.d = {sg, 8'(ex), qq[22:0]};
      end
    end
    return r;
  endfunction

  function automatic int latOf(input exp_t h);
    return h.special ? 1 : NORM_LAT;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Non-exact results may differ from the rounded quotient by one unit in the last place.
  task automatic checkResult(input exp_t h);
    int diff;
    bit ok;
    n_tests++;
    diff = int'(bus.d[30:0]) - int'(h.d[30:0]);
    if (h.exact) ok = (bus.d === h.d);
    else         ok = (bus.d[31] === h.d[31]) && diff >= -1 && diff <= 1;
    ok = ok && (bus.overflow === h.ovf) && (bus.underflow === h.unf);
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL result s=%h: got d=%h ovf=%b unf=%b, expected d=%h ovf=%b unf=%b%s",
               h.s, bus.d, bus.overflow, bus.underflow, h.d, h.ovf, h.unf, h.exact ? "" : " (+-1 ulp)");
    end
  endtask

  // Monitor: predicts on every accepted operand and checks outputs on every cycle they are valid.
  always @(negedge clk) begin
    exp_t h;
    if (!rstn) begin
      q.delete();
      checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
    end else begin
      checkOutput("in_ready iff idle", 32'(bus.in_ready), 32'(!bus.busy));
      if (q.size() != 0 && !q[0].seen && (bus.out_valid || cyc - q[0].t_acc >= latOf(q[0]))) begin
        q[0].seen = 1'b1;
        n_tests++;
        if (!bus.out_valid || cyc - q[0].t_acc != latOf(q[0])) begin
          n_fail++;
          $display("[TB] FAIL latency s=%h: got %0d cycles (out_valid=%0b), expected %0d",
                   q[0].s, cyc - q[0].t_acc, bus.out_valid, latOf(q[0]));
        end
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected output: got d=%h with no operand pending, expected none", bus.d);
        end else begin
          checkResult(q[0]);
          if (bus.out_ready) begin
            last_d = bus.d;
            last_ovf = bus.overflow;
            last_unf = bus.underflow;
            n_results++;
            void'(q.pop_front());
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        h = refModel(bus.s);
        h.t_acc = cyc + 1;
        q.push_back(h);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] val);
    int waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL accept timeout s=%h: got in_ready=0 for %0d cycles, expected 1", val, waited);
      return;
    end
    bus.in_valid = 1'b1;
    bus.s = val;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int waited = 0;
    while ((q.size() != 0 || bus.busy) && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    n_tests++;
    if (q.size() != 0 || bus.busy) begin
      n_fail++;
      $display("[TB] FAIL %s completion: got busy=%0b pending=%0d after %0d cycles, expected idle",
               name, bus.busy, q.size(), waited);
    end
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[30:23] = 8'($urandom_range(1, 252));
    if ($urandom_range(0, 15) == 0) r[22:0] = 23'd0;
    return r;
  endfunction

  logic [31:0] dir_s   [10] = '{32'h40000000, 32'h40400000, 32'hC0800000, 32'h00000000, 32'h7F000000,
                                32'h3F800000, 32'h7F800000, 32'hFFC00001, 32'h80000001, 32'h7E800001};
  logic [31:0] dir_d   [10] = '{32'h3F000000, 32'h3EAAAAAB, 32'hBE800000, 32'h7F800000, 32'h00000000,
                                32'h3F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h00000000};
  logic        dir_ovf [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        dir_unf [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t m;
    int nres, sent, guard;
    bit accepted;

    rstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.s = 32'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset d", bus.d, 32'd0);
    checkOutput("reset overflow", 32'(bus.overflow), 32'd0);
    checkOutput("reset underflow", 32'(bus.underflow), 32'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after reset", 32'(bus.in_ready), 32'd1);

    // The reference model itself against hand-worked values.
    m = refModel(32'h40000000); checkOutput("model 2.0", m.d, 32'h3F000000);
    m = refModel(32'h40400000); checkOutput("model 3.0", m.d, 32'h3EAAAAAB);
    m = refModel(32'hC0800000); checkOutput("model -4.0", m.d, 32'hBE800000);
    m = refModel(32'h00000000); checkOutput("model zero", {m.d[31:1], m.ovf}, 32'h7F800001);
    m = refModel(32'h7F000000); checkOutput("model underflow", {m.d[31:1], m.unf}, 32'h00000001);

    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(dir_s[i]);
      waitIdle("directed");
      checkOutput($sformatf("directed d s=%h", dir_s[i]), last_d, dir_d[i]);
      checkOutput($sformatf("directed flags s=%h", dir_s[i]), {30'd0, last_ovf, last_unf},
                  {30'd0, dir_ovf[i], dir_unf[i]});
    end

    // Consumer stalls: result must hold and a second operand must be ignored.
    bus.out_ready = 1'b0;
    nres = n_results;
    applyStimulus(32'h40000000);
    for (int i = 0; i < 20 && !bus.out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.s = 32'h40400000;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checkOutput("stall out_valid held", 32'(bus.out_valid), 32'd1);
    checkOutput("stall in_ready low", 32'(bus.in_ready), 32'd0);
    checkOutput("stall d held", bus.d, 32'h3F000000);
    bus.out_ready = 1'b1;
    waitIdle("stall");
    checkOutput("stall one result", 32'(n_results - nres), 32'd1);
    checkOutput("stall result d", last_d, 32'h3F000000);

    // Reset in the middle of an operation discards it.
    nres = n_results;
    applyStimulus(32'h40400000);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("reset discards op", 32'(n_results - nres), 32'd0);
    applyStimulus(32'h40000000);
    waitIdle("after reset");
    checkOutput("after reset d", last_d, 32'h3F000000);

    // Back-to-back random operands with a randomly stalling consumer.
    sent = 0;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.s = randOperand();
    while (sent < NRAND && guard < 40 * NRAND) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      accepted = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      guard++;
      if (accepted) begin
        sent++;
        if (sent < NRAND) bus.s = randOperand();
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("random ops accepted", 32'(sent), 32'(NRAND));
    waitIdle("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
